// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants for the multi-port register file.
//               c_DEFAULT_DATA_W   - default register width
//               c_DEFAULT_NUM_REGS - default register count
//               c_ZERO_REG         - address of the hardwired-zero register
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_DEFAULT_DATA_W   = 64;
    localparam int c_DEFAULT_NUM_REGS = 32;
    localparam int c_ZERO_REG         = 0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Per-register pending scoreboard. One pending bit per register.
//               A set marks a register pending (writer issued); a clear
//               (writeback) releases it. Set wins over clear on the same
//               register in the same cycle. Register 0 is never pending.
//               Lookups see the current-cycle set/clear (bypassed).
// Ports       : clk, rst_n        - clock, async active-low reset
//               set_en, set_addr  - mark register pending
//               clr0_en/clr0_addr - clear from write port 0
//               clr1_en/clr1_addr - clear from write port 1
//               ra                - packed lookup addresses (NUM_RD ports)
//               rd_pend           - pending bit per lookup port
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = c_DEFAULT_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr0_en,
    input  logic [ADDR_W-1:0]        clr0_addr,
    input  logic                     clr1_en,
    input  logic [ADDR_W-1:0]        clr1_addr,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD-1:0]        rd_pend
);

    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_pend_nxt;

    // Clear first, then set, so a same-cycle set overrides the clear.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (clr0_en && (clr0_addr == ADDR_W'(k))) w_pend_nxt[k] = 1'b0;
            if (clr1_en && (clr1_addr == ADDR_W'(k))) w_pend_nxt[k] = 1'b0;
            if (set_en  && (set_addr  == ADDR_W'(k))) w_pend_nxt[k] = 1'b1;
        end
        w_pend_nxt[c_ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Lookup reflects this cycle's set/clear so issue sees the state that
    // will hold after the edge.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_lookup
        logic [ADDR_W-1:0] w_a;
        logic              w_p;
        assign w_a = ra[i*ADDR_W +: ADDR_W];

        always_comb begin
            if (w_a == ADDR_W'(c_ZERO_REG)) begin
                w_p = 1'b0;
            end else if (set_en && (set_addr == w_a)) begin
                w_p = 1'b1;
            end else if ((clr0_en && (clr0_addr == w_a)) ||
                         (clr1_en && (clr1_addr == w_a))) begin
                w_p = 1'b0;
            end else begin
                w_p = r_pend[w_a];
            end
        end

        assign rd_pend[i] = w_p;
    end : g_lookup

endmodule : regfile_sb
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-port integer register file with hardwired-zero r0,
//               two prioritised synchronous write ports (port 1 wins on a
//               same-address collision), combinational reads with
//               write-to-read bypass, and a pending scoreboard for RAW
//               hazard detection.
// Ports       : clk, rst_n          - clock, async active-low reset
//               ra / rd             - packed read addresses / read data
//               rd_pend             - pending bit per read port
//               we0, wa0, wd0       - write port 0 (primary writeback)
//               we1, wa1, wd1       - write port 1 (secondary writeback)
//               sb_set, sb_addr     - mark register pending
//               wr_conflict         - previous cycle had a same-address
//                                     dual write to a nonzero register
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = c_DEFAULT_DATA_W,
    parameter int NUM_REGS = c_DEFAULT_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic                     wr_conflict
);

    // Effective enables: address 0 is never written, and while reset is
    // held nothing may bypass to the read ports, so reads show the cleared
    // state immediately.
    logic w_we0;
    logic w_we1;
    logic w_set;
    assign w_we0 = rst_n && we0 && (wa0 != ADDR_W'(c_ZERO_REG));
    assign w_we1 = rst_n && we1 && (wa1 != ADDR_W'(c_ZERO_REG));
    assign w_set = rst_n && sb_set && (sb_addr != ADDR_W'(c_ZERO_REG));

    logic [DATA_W-1:0] w_mem [NUM_REGS];

    // r0 has no storage; every other register is a reset-clearable flop.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        if (k == c_ZERO_REG) begin : g_zero
            assign w_mem[k] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (w_we1 && (wa1 == ADDR_W'(k))) begin
                    r_q <= wd1;
                end else if (w_we0 && (wa0 == ADDR_W'(k))) begin
                    r_q <= wd0;
                end
            end
            assign w_mem[k] = r_q;
        end
    end : g_reg

    // Read ports with bypass; port 1 has priority, matching the write order.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic [DATA_W-1:0] w_data;
        assign w_a = ra[i*ADDR_W +: ADDR_W];

        always_comb begin
            if (w_we1 && (wa1 == w_a)) begin
                w_data = wd1;
            end else if (w_we0 && (wa0 == w_a)) begin
                w_data = wd0;
            end else begin
                w_data = w_mem[w_a];
            end
        end

        assign rd[i*DATA_W +: DATA_W] = w_data;
    end : g_rd

    logic r_conflict;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= w_we0 && w_we1 && (wa0 == wa1);
        end
    end
    assign wr_conflict = r_conflict;

    regfile_sb #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (w_set),
        .set_addr  (sb_addr),
        .clr0_en   (w_we0),
        .clr0_addr (wa0),
        .clr1_en   (w_we1),
        .clr1_addr (wa1),
        .ra        (ra),
        .rd_pend   (rd_pend)
    );

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp. Expected values
//               are queued as stimulus is applied and popped/compared at each
//               sample point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int c_DW = 64;
    localparam int c_NR = 32;
    localparam int c_NP = 2;
    localparam int c_AW = 5;

    logic                  clk;
    logic                  rst_n;
    logic [c_NP*c_AW-1:0]  ra;
    logic [c_NP*c_DW-1:0]  rd;
    logic [c_NP-1:0]       rd_pend;
    logic                  we0;
    logic [c_AW-1:0]       wa0;
    logic [c_DW-1:0]       wd0;
    logic                  we1;
    logic [c_AW-1:0]       wa1;
    logic [c_DW-1:0]       wd1;
    logic                  sb_set;
    logic [c_AW-1:0]       sb_addr;
    logic                  wr_conflict;

    regfile_mp #(
        .DATA_W   (c_DW),
        .NUM_REGS (c_NR),
        .NUM_RD   (c_NP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ra          (ra),
        .rd          (rd),
        .rd_pend     (rd_pend),
        .we0         (we0),
        .wa0         (wa0),
        .wd0         (wd0),
        .we1         (we1),
        .wa1         (wa1),
        .wd1         (wd1),
        .sb_set      (sb_set),
        .sb_addr     (sb_addr),
        .wr_conflict (wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = read data, 1 = pending bit, 2 = wr_conflict
    typedef struct {
        int          kind;
        int          port;
        logic [63:0] val;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input int p, input int a);
        ra[p*c_AW +: c_AW] = c_AW'(a);
    endtask

    task automatic expect_v(input int kind, input int port, input logic [63:0] v, input string tag);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.val  = v;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    function automatic logic [63:0] observe(input int kind, input int port);
        logic [63:0] o;
        case (kind)
            0:       o = rd[port*c_DW +: c_DW];
            1:       o = {63'd0, rd_pend[port]};
            default: o = {63'd0, wr_conflict};
        endcase
        return o;
    endfunction

    task automatic check_all();
        exp_t        e;
        logic [63:0] obs;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.kind, e.port);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        sb_set = 1'b0; sb_addr = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        ra    = '0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Populate a register and a pending bit, then pulse reset mid-cycle.
        we0 = 1'b1; wa0 = 5'd4; wd0 = 64'h77;
        sb_set = 1'b1; sb_addr = 5'd6;
        tick();
        idle_inputs();
        set_ra(0, 4);
        #1;
        expect_v(0, 0, 64'h77, "pre_reset_r4");
        check_all();
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < c_NR; a++) begin
            set_ra(0, a);
            set_ra(1, c_NR - 1 - a);
            #0.1;
            expect_v(0, 0, 64'h0, "reset_rd0");
            expect_v(0, 1, 64'h0, "reset_rd1");
            expect_v(1, 0, 64'h0, "reset_pend0");
            expect_v(1, 1, 64'h0, "reset_pend1");
            check_all();
        end
        expect_v(2, 0, 64'h0, "reset_conflict");
        check_all();
        tick();

        // Writes to r0 are dropped.
        we0 = 1'b1; wa0 = 5'd0; wd0 = 64'hDEAD;
        sb_set = 1'b1; sb_addr = 5'd0;
        set_ra(0, 0);
        #1;
        expect_v(0, 0, 64'h0, "r0_bypass");
        check_all();
        tick();
        idle_inputs();
        #1;
        expect_v(0, 0, 64'h0, "r0_read");
        expect_v(1, 0, 64'h0, "r0_pend");
        check_all();

        // Basic write/read on both ports.
        we0 = 1'b1; wa0 = 5'd5; wd0 = 64'hA5A5;
        tick();
        idle_inputs();
        set_ra(0, 5);
        set_ra(1, 5);
        #1;
        expect_v(0, 0, 64'hA5A5, "r5_port0");
        expect_v(0, 1, 64'hA5A5, "r5_port1");
        check_all();

        // Port 1 alone writes.
        we1 = 1'b1; wa1 = 5'd3; wd1 = 64'h3333;
        tick();
        idle_inputs();
        set_ra(1, 3);
        #1;
        expect_v(0, 1, 64'h3333, "r3_port1_write");
        check_all();

        // Bypass before the edge, storage after.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 64'h11;
        set_ra(0, 7);
        #1;
        expect_v(0, 0, 64'h11, "bypass_pre_edge");
        check_all();
        tick();
        idle_inputs();
        #1;
        expect_v(0, 0, 64'h11, "bypass_post_edge");
        check_all();

        // Dual write collision: port 1 wins, conflict flag for one cycle.
        we0 = 1'b1; wa0 = 5'd9; wd0 = 64'h1;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 64'h2;
        set_ra(0, 9);
        #1;
        expect_v(0, 0, 64'h2, "collision_bypass");
        expect_v(2, 0, 64'h0, "conflict_before_edge");
        check_all();
        tick();
        idle_inputs();
        #1;
        expect_v(0, 0, 64'h2, "collision_r9");
        expect_v(2, 0, 64'h1, "conflict_set");
        check_all();
        tick();
        expect_v(2, 0, 64'h0, "conflict_one_cycle");
        check_all();

        // Different-address dual write raises no conflict.
        we0 = 1'b1; wa0 = 5'd10; wd0 = 64'hA;
        we1 = 1'b1; wa1 = 5'd11; wd1 = 64'hB;
        tick();
        idle_inputs();
        set_ra(0, 10);
        set_ra(1, 11);
        #1;
        expect_v(0, 0, 64'hA, "dual_r10");
        expect_v(0, 1, 64'hB, "dual_r11");
        expect_v(2, 0, 64'h0, "no_conflict");
        check_all();

        // Scoreboard step 1: set.
        sb_set = 1'b1; sb_addr = 5'd12;
        set_ra(1, 12);
        #1;
        expect_v(1, 1, 64'h1, "sb_set_bypass");
        check_all();
        tick();
        idle_inputs();
        #1;
        expect_v(1, 1, 64'h1, "sb_set");
        check_all();

        // Step 2: write plus set on same register keeps it pending.
        we0 = 1'b1; wa0 = 5'd12; wd0 = 64'h40;
        sb_set = 1'b1; sb_addr = 5'd12;
        #1;
        expect_v(1, 1, 64'h1, "sb_set_wins_bypass");
        check_all();
        tick();
        idle_inputs();
        #1;
        expect_v(1, 1, 64'h1, "sb_set_wins");
        check_all();

        // Step 3: plain write via port 1 clears.
        we1 = 1'b1; wa1 = 5'd12; wd1 = 64'h55;
        #1;
        expect_v(1, 1, 64'h0, "sb_clear_bypass");
        check_all();
        tick();
        idle_inputs();
        #1;
        expect_v(1, 1, 64'h0, "sb_clear");
        expect_v(0, 1, 64'h55, "r12_data");
        check_all();

        // Async reset while writes to r3 are active.
        sb_set = 1'b1; sb_addr = 5'd3;
        tick();
        idle_inputs();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 64'h44;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 64'h45;
        sb_set = 1'b1; sb_addr = 5'd3;
        set_ra(0, 3);
        set_ra(1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        expect_v(0, 0, 64'h0, "rst_r3_immediate");
        expect_v(1, 0, 64'h0, "rst_pend3_immediate");
        expect_v(0, 1, 64'h0, "rst_r5_immediate");
        check_all();
        tick();
        expect_v(0, 0, 64'h0, "rst_r3_held_edge");
        expect_v(1, 0, 64'h0, "rst_pend3_held_edge");
        expect_v(2, 0, 64'h0, "rst_conflict_held");
        check_all();
        idle_inputs();
        rst_n = 1'b1;
        tick();
        expect_v(0, 0, 64'h0, "rst_r3_after_release");
        expect_v(1, 0, 64'h0, "rst_pend3_after_release");
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_mp
`default_nettype wire
